// File: rtl/rcc_clk_div_mc.sv
// Multi-channel dynamic clock divider; ratio changes take effect only at a period boundary.
// Optional RCC_DIV_ALIGN_EN adds align_req to phase-align all running channels.
module rcc_clk_div_mc #(
    parameter int unsigned NCH       = 4,
    parameter int unsigned RATIO_WID = 8,
    parameter int unsigned RST_RATIO = 0
) (
    input  logic                     i_clk,
    input  logic                     rst,
    input  logic [NCH-1:0]           upd_req,
    input  logic [NCH*RATIO_WID-1:0] ratio,
`ifdef RCC_DIV_ALIGN_EN
    input  logic                     align_req,
`endif
    output logic [NCH-1:0]           upd_ack,
    output logic [NCH-1:0]           busy,
    output logic [NCH-1:0]           o_clk,
    output logic [NCH-1:0]           div_en
);

    typedef logic [RATIO_WID-1:0] ratio_t;
    typedef enum logic {IDLE, RUN} state_e;

    localparam ratio_t RST_R = ratio_t'(RST_RATIO);

    function automatic ratio_t eff_ratio(input ratio_t r);
        return (r == ratio_t'(1)) ? ratio_t'(2) : r;
    endfunction

    // ceil(r/2) without needing an extra bit for r+1
    function automatic ratio_t high_len(input ratio_t r);
        return (r >> 1) + ratio_t'(r[0]);
    endfunction

    state_e         state_q [NCH];
    state_e         state_d [NCH];
    ratio_t         cnt_q   [NCH];
    ratio_t         cnt_d   [NCH];
    ratio_t         cur_q   [NCH];
    ratio_t         cur_d   [NCH];
    ratio_t         pend_q  [NCH];
    ratio_t         pend_d  [NCH];
    logic [NCH-1:0] busy_q, busy_d;
    logic [NCH-1:0] ack_q,  ack_d;
    logic [NCH-1:0] oclk_q, oclk_d;
    logic [NCH-1:0] en_q,   en_d;
    logic           align_w;

`ifdef RCC_DIV_ALIGN_EN
    assign align_w = align_req;
`else
    assign align_w = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                state_q[c] <= IDLE;
                cnt_q[c]   <= '0;
                cur_q[c]   <= RST_R;
                pend_q[c]  <= '0;
            end
            busy_q <= '0;
            ack_q  <= '0;
            oclk_q <= '0;
            en_q   <= '0;
        end else begin
            for (int unsigned c = 0; c < NCH; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
                cur_q[c]   <= cur_d[c];
                pend_q[c]  <= pend_d[c];
            end
            busy_q <= busy_d;
            ack_q  <= ack_d;
            oclk_q <= oclk_d;
            en_q   <= en_d;
        end
    end

    always_comb begin
        ratio_t req_r;
        ratio_t r_cur;
        ratio_t new_r;
        ratio_t cnt_inc;
        logic   apply;
        busy_d = busy_q;
        ack_d  = '0;
        oclk_d = oclk_q;
        en_d   = en_q;
        for (int unsigned c = 0; c < NCH; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            cur_d[c]   = cur_q[c];
            pend_d[c]  = pend_q[c];
            req_r      = ratio[c*RATIO_WID +: RATIO_WID];
            r_cur      = eff_ratio(cur_q[c]);
            cnt_inc    = cnt_q[c] + ratio_t'(1);
            new_r      = cur_q[c];
            apply      = 1'b0;
            case (state_q[c])
                IDLE: begin
                    oclk_d[c] = 1'b0;
                    en_d[c]   = 1'b0;
                    if (upd_req[c]) begin
                        new_r    = req_r;
                        cur_d[c] = req_r;
                        ack_d[c] = 1'b1;
                    end
                    // Also covers the first edge after reset when RST_RATIO is non-zero
                    if (eff_ratio(new_r) != '0) begin
                        state_d[c] = RUN;
                        cnt_d[c]   = '0;
                        oclk_d[c]  = 1'b1;
                        en_d[c]    = 1'b1;
                    end
                end
                RUN: begin
                    if ((cnt_q[c] == r_cur - ratio_t'(1)) || align_w) begin
                        if (upd_req[c]) begin
                            apply = 1'b1;
                            new_r = req_r;
                        end else if (busy_q[c]) begin
                            apply = 1'b1;
                            new_r = pend_q[c];
                        end
                        cnt_d[c]  = '0;
                        oclk_d[c] = 1'b1;
                        if (apply) begin
                            cur_d[c]  = new_r;
                            busy_d[c] = 1'b0;
                            ack_d[c]  = 1'b1;
                            if (new_r == '0) begin
                                state_d[c] = IDLE;
                                oclk_d[c]  = 1'b0;
                                en_d[c]    = 1'b0;
                            end
                        end
                    end else begin
                        cnt_d[c]  = cnt_inc;
                        oclk_d[c] = (cnt_inc < high_len(r_cur));
                        if (upd_req[c]) begin
                            pend_d[c] = req_r;
                            busy_d[c] = 1'b1;
                        end
                    end
                end
                default: state_d[c] = IDLE;
            endcase
        end
    end

    always_comb begin
        upd_ack = ack_q;
        busy    = busy_q;
        o_clk   = oclk_q;
        div_en  = en_q;
    end

endmodule

// File: doc/rcc_clk_div_mc.md
Name: rcc_clk_div_mc

Overview:
Multi-channel dynamic clock divider with a per-channel ratio-update handshake. It divides i_clk by a per-channel runtime ratio. Ratio changes are deferred to the end of the current output period, so no output has a runt or glitch. Sits in the RCC between the register/control domain (already synchronised to i_clk) and the per-peripheral kernel clock trees.

Parameters:
NCH, 4, number of independent divider channels (1..16)
RATIO_WID, 8, width of each channel's ratio field
RST_RATIO, 0, ratio every channel holds after reset (0 = channel stopped)

Ports:
i_clk  input  1  source clock; all flops on rising edge
rst  input  1  asynchronous active-high reset
upd_req  input  NCH  per-channel single-cycle request to load a new ratio
ratio  input  NCH*RATIO_WID  requested ratios; channel c uses bits [c*RATIO_WID +: RATIO_WID]; sampled only when upd_req[c]=1
upd_ack  output  NCH  one-cycle pulse: the new ratio has taken effect
busy  output  NCH  a ratio is pending (accepted, not yet applied)
o_clk  output  NCH  divided clocks, each driven directly from a flop
div_en  output  NCH  channel running (ratio != 0)

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-high on rst.
- Reset values, all channels: o_clk=0, div_en=0, upd_ack=0, busy=0, cnt=0, cur_ratio=RST_RATIO, state=IDLE.
- Effective ratio R = cur_ratio, except 1 is clamped to 2; R=0 means stopped.
- Per-channel FSM, IDLE/RUN; channels fully independent.
- IDLE: o_clk=0, div_en=0.
  - If upd_req=1 at an edge: cur_ratio<=ratio, upd_ack<=1 (one cycle), busy stays 0.
  - If the new R != 0: state<=RUN, cnt<=0, o_clk<=1, div_en<=1, all on that same edge.
  - First edge after rst deasserts with RST_RATIO != 0: enter RUN the same way, with no ack.
- RUN: cnt counts 0..R-1 and wraps. H = ceil(R/2).
  - o_clk flop is high while cnt<H and low while cnt>=H (odd R: high phase one cycle longer). Period = R i_clk cycles.
- upd_req in RUN at a non-wrap edge (cnt != R-1): pend<=ratio, busy<=1. A later upd_req before the wrap overwrites pend; only one ack is produced, for the last value.
- Wrap edge (cnt=R-1), with pend valid or upd_req=1 at this edge (upd_req takes priority over pend):
  - cur_ratio<=new value, busy<=0, upd_ack<=1.
  - New R != 0: cnt<=0, o_clk<=1, stay RUN.
  - New R = 0: state<=IDLE, o_clk<=0, div_en<=0.
- Wrap edge with nothing pending: cnt<=0, o_clk<=1.
- Stopping always completes the low phase first, so no shortened high or low pulse.
- upd_ack is asserted in the first cycle the new ratio is in effect: cnt=0 with o_clk=1, or IDLE.
- Request to the same ratio: still handshaken, ack at the period boundary.
- Reset mid-period: outputs drop immediately (async), pending request discarded, channel returns to IDLE with cur_ratio=RST_RATIO.
- Width: cnt and H are RATIO_WID bits; R up to 2^RATIO_WID-1; no overflow possible.

Optional Feature:
Macro RCC_DIV_ALIGN_EN.
- Defined: adds input align_req (1 bit).
  - At an edge with align_req=1, every RUN channel forces cnt<=0 and o_clk<=1, so all channels get phase-aligned rising edges.
  - Pending ratios are applied at this edge as if it were a wrap, with upd_ack pulses. IDLE channels are unaffected.
  - Alignment may truncate the current period; software issues it only while downstream clocks are gated.
- Not defined: port absent, no alignment logic.

Test Plan:
1. RST_RATIO=0; ch0 upd_req with ratio=4 -> next cycle upd_ack[0]=1, o_clk[0] pattern 1100 repeating, div_en[0]=1.
2. ch1 running ratio=5; upd_req ratio=2 at cnt=1 -> busy[1]=1 for 3 cycles; 3-high/2-low period completes; then upd_ack[1]=1 with o_clk pattern 10 repeating.
3. ch2 running ratio=3; upd_req ratio=0 -> current 110 period finishes, then o_clk=0 held, div_en[2]=0, upd_ack[2]=1; a later upd_req ratio=1 -> o_clk pattern 10 (clamped to 2).
4. Two upd_req on ch3 within one ratio=8 period (6 then 7) -> single upd_ack; next period length 7 with 4 high/3 low.
5. rst asserted asynchronously mid-high-phase with a pending request -> o_clk, div_en, busy, upd_ack drop at once; after release with RST_RATIO=0, all channels stay IDLE.
6. RCC_DIV_ALIGN_EN defined, channels at ratios 3 and 4 out of phase; align_req pulse -> next cycle both o_clk=1 with cnt=0, then run at their own periods.
